// File: rtl/modulo_transferencia_rolhas_pkg.sv
// Shared definitions for the cork transfer stage.
// Holds the count width, the lot and level limits, the FSM state encoding,
// and the lot-size helper used when a transfer lot is loaded.
package modulo_transferencia_rolhas_pkg;

  localparam int W = 7;

  localparam logic [W-1:0] LOTE     = W'(20);  // max corks moved per lot
  localparam logic [W-1:0] MIN_LVL  = W'(5);   // refill threshold
  localparam logic [W-1:0] PRIM_MAX = W'(99);  // primary capacity / display limit

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    XFER = 2'b10,
    DONE = 2'b11
  } state_t;

  // Lot size = min(LOTE, secondary count, free room in the primary buffer).
  function automatic logic [W-1:0] lot_size(input logic [W-1:0] sec,
                                            input logic [W-1:0] prim);
    logic [W-1:0] room;
    logic [W-1:0] m;
    room = PRIM_MAX - prim;
    m    = LOTE;
    if (sec < m)  m = sec;
    if (room < m) m = room;
    return m;
  endfunction

endpackage

// File: rtl/modulo_detector_borda.sv
// Rising-edge detector for the sealing level signal.
// Ports:
//   clk  - system clock
//   Nclr - synchronous active-low clear of the level register
//   din  - level input
//   rise - high for the clk in which din is 1 and was 0 at the previous edge
module modulo_detector_borda (
  input  logic clk,
  input  logic Nclr,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (!Nclr) din_q <= 1'b0;
    else       din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/modulo_transferencia_rolhas.sv
// Primary cork buffer with lot transfer from the secondary buffer.
// Refills the primary buffer in lots when it falls below MIN_LVL (or on a
// manual request), one cork per tick, issuing a one-clk sec_dec pulse for
// every cork taken from the secondary. Each rising edge of ve consumes one
// cork from the primary buffer.
// Ports:
//   clk, Nclr      - clock, synchronous active-low reset
//   tick           - step enable for transfer moves
//   ve             - sealing level; rising edge consumes one cork
//   sec_count      - current secondary buffer count
//   req_manual     - one-clk request to start a lot (honoured only in IDLE)
//   prim_count     - primary buffer count
//   sec_dec        - one-clk pulse per cork moved
//   ro, min_signal - primary empty / below MIN_LVL
//   busy           - lot in progress (XFER)
//   xfer_done      - one-clk pulse at lot end
//   short_lot      - sticky: last lot cut short by an empty secondary
//   underflow      - sticky: consume seen with an empty primary
//   state          - current FSM state (IDLE/LOAD/XFER/DONE encoding)
//
// Handshake: sec_dec is a strobe with no back-pressure; the secondary must
// decrement by one in every clk where sec_dec is high.
module modulo_transferencia_rolhas
  import modulo_transferencia_rolhas_pkg::*;
(
  input  logic         clk,
  input  logic         Nclr,
  input  logic         tick,
  input  logic         ve,
  input  logic [W-1:0] sec_count,
  input  logic         req_manual,
  output logic [W-1:0] prim_count,
  output logic         sec_dec,
  output logic         ro,
  output logic         min_signal,
  output logic         busy,
  output logic         xfer_done,
  output logic         short_lot,
  output logic         underflow,
  output logic [1:0]   state
);

  state_t       st;
  logic [W-1:0] rem;
  logic         consume;
  logic         start;
  logic         step;

  modulo_detector_borda u_borda (
    .clk  (clk),
    .Nclr (Nclr),
    .din  (ve),
    .rise (consume)
  );

  assign start = ((prim_count < MIN_LVL) || req_manual) &&
                 (sec_count != '0) && (prim_count < PRIM_MAX);

  // A move happens only on a tick with cork left in the lot, cork available
  // upstream and room downstream.
  assign step = (st == XFER) && tick && (rem != '0) &&
                (sec_count != '0) && (prim_count != PRIM_MAX);

  always_ff @(posedge clk) begin
    if (!Nclr) begin
      st         <= IDLE;
      rem        <= '0;
      prim_count <= '0;
      sec_dec    <= 1'b0;
      xfer_done  <= 1'b0;
      short_lot  <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      sec_dec   <= 1'b0;
      xfer_done <= 1'b0;

      // A cork arriving and a cork leaving in the same clk cancel out.
      if (step && !consume) begin
        prim_count <= prim_count + W'(1);
      end else if (consume && !step) begin
        if (prim_count != '0) prim_count <= prim_count - W'(1);
        else                  underflow  <= 1'b1;
      end

      case (st)
        IDLE: if (start) st <= LOAD;
        LOAD: begin
          rem       <= lot_size(sec_count, prim_count);
          short_lot <= 1'b0;
          st        <= XFER;
        end
        XFER: begin
          if (rem == '0 || prim_count == PRIM_MAX) begin
            st <= DONE;
          end else if (sec_count == '0) begin
            short_lot <= 1'b1;
            st        <= DONE;
          end else if (step) begin
            rem     <= rem - W'(1);
            sec_dec <= 1'b1;
            if (rem == W'(1)) st <= DONE;
          end
        end
        DONE: begin
          xfer_done <= 1'b1;
          st        <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign ro         = (prim_count == '0);
  assign min_signal = (prim_count < MIN_LVL);
  assign busy       = (st == XFER);
  assign state      = st;

endmodule

// File: tb/tb_modulo_transferencia_rolhas.sv
// Directed bench for the cork transfer stage. The secondary buffer is
// emulated: each sampled sec_dec pulse decrements sec_count.
module tb_modulo_transferencia_rolhas;
  import modulo_transferencia_rolhas_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         Nclr;
  logic         tick;
  logic         ve;
  logic [W-1:0] sec_count;
  logic         req_manual;
  logic [W-1:0] prim_count;
  logic         sec_dec;
  logic         ro;
  logic         min_signal;
  logic         busy;
  logic         xfer_done;
  logic         short_lot;
  logic         underflow;
  logic [1:0]   state;

  modulo_transferencia_rolhas dut (
    .clk        (clk),
    .Nclr       (Nclr),
    .tick       (tick),
    .ve         (ve),
    .sec_count  (sec_count),
    .req_manual (req_manual),
    .prim_count (prim_count),
    .sec_dec    (sec_dec),
    .ro         (ro),
    .min_signal (min_signal),
    .busy       (busy),
    .xfer_done  (xfer_done),
    .short_lot  (short_lot),
    .underflow  (underflow),
    .state      (state)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  int dec_cnt  = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver: apply inputs, clock once, sample #1 after the edge
  task automatic cyc(input logic t, input logic v, input logic r);
    tick       = t;
    ve         = v;
    req_manual = r;
    @(posedge clk);
    #1;
    if (sec_dec) begin
      dec_cnt++;
      if (sec_count != '0) sec_count = sec_count - W'(1);
    end
    if (xfer_done) done_cnt++;
  endtask

  task automatic clr_counts();
    dec_cnt  = 0;
    done_cnt = 0;
  endtask

  // manual lot: request, load, then tick until xfer_done (bounded)
  task automatic do_lot(input int s, input string tag);
    bit seen;
    seen = 0;
    sec_count = W'(s);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc(1, 0, 0);
      if (xfer_done) seen = 1;
    end
    check({tag, "_done_seen"}, int'(seen), 1);
  endtask

  initial begin
    Nclr = 1'b0; tick = 1'b0; ve = 1'b0; req_manual = 1'b0; sec_count = '0;

    // ---- reset state
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("rst_prim", int'(prim_count), 0);
    check("rst_ro", int'(ro), 1);
    check("rst_min", int'(min_signal), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_dec", int'(sec_dec), 0);
    check("rst_state", int'(state), 0);
    Nclr = 1'b1;
    cyc(0, 0, 0);
    check("idle_no_sec", int'(state), 0);

    // ---- full lot of 20 from sec=30, tick every clk
    clr_counts();
    sec_count = W'(30);
    cyc(1, 0, 0);
    check("t1_load", int'(state), 1);
    cyc(1, 0, 0);
    check("t1_xfer", int'(state), 2);
    check("t1_busy", int'(busy), 1);
    for (int i = 0; i < 23; i++) cyc(1, 0, 0);
    check("t1_prim", int'(prim_count), 20);
    check("t1_decs", dec_cnt, 20);
    check("t1_done", done_cnt, 1);
    check("t1_busy_end", int'(busy), 0);
    check("t1_short", int'(short_lot), 0);
    check("t1_sec", int'(sec_count), 10);

    // ---- 16 consumes from 20 -> 4, then lot of 7
    clr_counts();
    sec_count = W'(7);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 0);
      cyc(0, 0, 0);
    end
    check("t2_prim4", int'(prim_count), 4);
    check("t2_load", int'(state), 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("t2_no_tick_hold", int'(prim_count), 4);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0);
    check("t2_prim11", int'(prim_count), 11);
    check("t2_decs", dec_cnt, 7);
    check("t2_done", done_cnt, 1);
    check("t2_short", int'(short_lot), 0);

    // ---- short lot: secondary emptied mid-lot
    clr_counts();
    sec_count = W'(3);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    sec_count = '0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("t2s_short", int'(short_lot), 1);
    check("t2s_prim", int'(prim_count), 12);
    check("t2s_done", done_cnt, 1);
    check("t2s_state", int'(state), 0);

    // ---- underflow with empty primary and empty secondary
    clr_counts();
    Nclr = 1'b0;
    cyc(0, 0, 0);
    check("t3_short_clr", int'(short_lot), 0);
    Nclr = 1'b1;
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("t3_prim", int'(prim_count), 0);
    check("t3_underflow", int'(underflow), 1);
    check("t3_ro", int'(ro), 1);
    check("t3_decs", dec_cnt, 0);
    check("t3_state", int'(state), 0);

    // ---- consume and step in the same clk
    clr_counts();
    sec_count = W'(10);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    check("t4_prim3", int'(prim_count), 3);
    cyc(1, 1, 0);
    check("t4_same_prim", int'(prim_count), 3);
    check("t4_same_dec", int'(sec_dec), 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0);
    check("t4_done_state", int'(state), 3);
    cyc(0, 0, 0);
    check("t4_prim9", int'(prim_count), 9);
    check("t4_decs", dec_cnt, 10);
    check("t4_done", done_cnt, 1);
    check("t4_underflow_sticky", int'(underflow), 1);

    // ---- fill to 99 via manual lots
    do_lot(50, "t5a");
    do_lot(50, "t5b");
    do_lot(50, "t5c");
    do_lot(50, "t5d");
    check("t5_prim89", int'(prim_count), 89);
    do_lot(1, "t5e");
    check("t5_prim90", int'(prim_count), 90);
    clr_counts();
    do_lot(50, "t5f");
    check("t5_prim99", int'(prim_count), 99);
    check("t5_decs9", dec_cnt, 9);
    check("t5_min", int'(min_signal), 0);
    check("t5_ro", int'(ro), 0);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    check("t5_no_load", int'(state), 0);
    check("t5_prim_hold", int'(prim_count), 99);
    check("t5_decs_hold", dec_cnt, 9);

    // ---- reset mid-lot
    Nclr = 1'b0;
    cyc(0, 0, 0);
    Nclr = 1'b1;
    sec_count = '0;
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("t6_underflow_set", int'(underflow), 1);
    sec_count = W'(20);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0);
    check("t6_prim8", int'(prim_count), 8);
    check("t6_busy", int'(busy), 1);
    Nclr = 1'b0;
    cyc(1, 0, 0);
    check("t6_prim", int'(prim_count), 0);
    check("t6_busy_clr", int'(busy), 0);
    check("t6_dec", int'(sec_dec), 0);
    check("t6_ro", int'(ro), 1);
    check("t6_underflow_clr", int'(underflow), 0);
    check("t6_short_clr", int'(short_lot), 0);
    check("t6_state", int'(state), 0);
    Nclr = 1'b1;
    cyc(0, 0, 0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/modulo_transferencia_rolhas.md
Name: modulo_transferencia_rolhas

Overview:
Downstream stage of the cork (rolha) secondary-buffer logic. Holds the primary cork buffer that feeds the sealing station. When the primary level drops below a minimum, it moves corks one at a time from the secondary buffer in lots of LOTE. Each move is signalled to the secondary counter through a one-clock decrement pulse. It also consumes one cork per sealing event and drives ro and min_signal toward the filling/sealing MEF and the display encoders.

Parameters:
W, 7, width of all cork counts
LOTE, 20, maximum corks moved per transfer lot
MIN_LVL, 5, primary level below which a transfer is requested
PRIM_MAX, 99, primary buffer capacity (display limit)

Ports:
clk  input  1  system clock (divided clock domain)
Nclr  input  1  synchronous active-low reset
tick  input  1  one-clk step enable; transfers advance only on tick
ve  input  1  sealing output from MEF (level); rising edge = one cork consumed
sec_count  input  W  current secondary buffer count
req_manual  input  1  one-clk pulse; forces a lot transfer regardless of MIN_LVL
prim_count  output  W  primary buffer count (registered)
sec_dec  output  1  one-clk pulse; secondary must decrement by 1
ro  output  1  1 when prim_count == 0
min_signal  output  1  1 when prim_count < MIN_LVL
busy  output  1  1 while in XFER
xfer_done  output  1  one-clk pulse at lot end
short_lot  output  1  sticky; lot ended early because secondary was empty
underflow  output  1  sticky; consume requested while prim_count == 0

Behaviour:
- Reset (Nclr=0 sampled at clk edge):
  - prim_count=0, sec_dec=0, busy=0, xfer_done=0, short_lot=0, underflow=0.
  - State=IDLE; ve edge-detect register cleared.
  - ro=1 and min_signal=1 follow from prim_count=0.
- Reset mid-lot aborts the lot immediately. No sec_dec is issued in the reset cycle.
- ve edge detect: consume=ve & ~ve_q, evaluated every clk, independent of tick.
- States:
  - IDLE: go to LOAD when (prim_count<MIN_LVL or req_manual) and sec_count>0 and prim_count<PRIM_MAX. Otherwise stay.
  - LOAD (1 clk): rem = min(LOTE, sec_count, PRIM_MAX-prim_count). Clear short_lot. Go to XFER.
  - XFER: on each tick with rem>0 and sec_count>0: prim_count+1, sec_dec=1 for that clk, rem-1.
    - rem reaches 0 → DONE.
    - sec_count==0 while rem>0 → set short_lot, go to DONE.
    - prim_count==PRIM_MAX → go to DONE.
  - DONE (1 clk): xfer_done=1, then IDLE.
- Latency:
  - Trigger condition to LOAD: 1 clk. LOAD to XFER: 1 clk.
  - First increment on the first tick seen while in XFER.
  - Lot of N corks needs N ticks.
- Consume with prim_count>0: prim_count-1.
- Consume with prim_count==0: prim_count stays 0, underflow set (sticky until reset).
- Consume and transfer step in the same clk: prim_count unchanged, sec_dec still 1, rem still decrements.
- prim_count never exceeds PRIM_MAX and never wraps below 0.
- sec_dec is never asserted in two consecutive clks unless tick is asserted in both. sec_dec is never asserted when sec_count==0.
- req_manual outside IDLE is ignored (not queued).
- Arithmetic: unsigned W-bit. The min() compare is done at W bits.

Decomposition:
- Shared package: W, LOTE, MIN_LVL, PRIM_MAX; state encoding IDLE=2'b00, LOAD=2'b01, XFER=2'b10, DONE=2'b11.
- One natural sub-module: modulo_detector_borda (rising-edge detector for ve: registered level plus AND-NOT, synchronous active-low clear).
- Remaining logic stays in the top: rem counter, prim up/down counter, FSM.

Test Plan:
- Reset, then sec_count=30, tick every clk → after LOAD: 20 sec_dec pulses, prim_count=20, xfer_done pulse once, busy low, short_lot=0.
- prim_count=20, sec_count=7: 16 ve rising edges → prim_count=4, then lot starts. rem=7; after 7 ticks prim_count=11; short_lot=1 once sec_count is driven to 0 with rem=0 handling verified.
- prim_count=0, no secondary (sec_count=0), one ve edge → prim_count=0, underflow=1, ro=1, no sec_dec, state stays IDLE.
- During XFER with prim_count=3, drive a ve edge in the same clk as a tick → prim_count stays 3, sec_dec=1, rem decrements by 1.
- prim_count=90, req_manual pulse, sec_count=50 → rem=9; after 9 ticks prim_count=99, DONE; further req_manual gives no transfer.
- Nclr low for 1 clk mid-XFER (prim_count=8) → next cycle prim_count=0, busy=0, sec_dec=0, ro=1, all sticky flags cleared.
